// File: rtl/cla_seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package cla_seq_divider_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_seq_divider_sub4.sv
// 4-bit carry-lookahead subtractor slice: diff = a + ~b + cin, cout high means no borrow.
module cla_sub4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] diff,
  output logic       cout
);

  logic [3:0] bn;
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign bn = ~b;
  assign g  = a & bn;
  assign p  = a ^ bn;

  // Lookahead carries in the same form as the adder family's lookahead unit
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign diff = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/cla_seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock, start/done handshake.
module cla_seq_divider
  import cla_seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned NSLICE = (WIDTH + SLICE_W) / SLICE_W;
  localparam int unsigned EXT_W  = NSLICE * SLICE_W;
  localparam int unsigned CNT_W  = $clog2(WIDTH + 1);

  state_t             state;
  logic [WIDTH-1:0]   divisor_r;
  logic [WIDTH-1:0]   q_r;
  logic [WIDTH:0]     rem_r;
  logic [CNT_W-1:0]   count;

  logic [WIDTH:0]     rem_sh;
  logic [EXT_W-1:0]   sub_a;
  logic [EXT_W-1:0]   sub_b;
  logic [EXT_W-1:0]   trial;
  logic [NSLICE:0]    carry;
  logic               no_borrow;
  logic [WIDTH:0]     rem_next;
  logic [WIDTH-1:0]   q_next;
  logic               unused_bits;

  assign rem_sh = {rem_r[WIDTH-1:0], q_r[WIDTH-1]};
  assign sub_a  = EXT_W'(rem_sh);
  assign sub_b  = EXT_W'(divisor_r);
  assign carry[0] = 1'b1;

  // Ripple-chained lookahead slices forming rem_sh - divisor
  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    cla_sub4 u_sub (
      .a    (sub_a[i*SLICE_W +: SLICE_W]),
      .b    (sub_b[i*SLICE_W +: SLICE_W]),
      .cin  (carry[i]),
      .diff (trial[i*SLICE_W +: SLICE_W]),
      .cout (carry[i+1])
    );
  end

  assign no_borrow = carry[NSLICE];
  assign rem_next  = no_borrow ? trial[WIDTH:0] : rem_sh;
  assign q_next    = {q_r[WIDTH-2:0], no_borrow};

  // Upper trial bits are zero whenever they would be used; rem_r[WIDTH] is shifted out
  assign unused_bits = ^{trial[EXT_W-1:WIDTH+1], rem_r[WIDTH]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      divisor_r   <= '0;
      q_r         <= '0;
      rem_r       <= '0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            divisor_r   <= divisor;
            q_r         <= dividend;
            rem_r       <= '0;
            count       <= CNT_W'(WIDTH);
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          rem_r <= rem_next;
          q_r   <= q_next;
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_next;
            remainder <= rem_next[WIDTH-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_divider.sv
// Self-checking bench for cla_seq_divider at WIDTH=8 and WIDTH=12.
module tb_cla_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        start8;
  logic [7:0]  dvd8, dvs8, q8, r8;
  logic        busy8, done8, z8;

  logic        start12;
  logic [11:0] dvd12, dvs12, q12, r12;
  logic        busy12, done12, z12;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  cla_seq_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .dividend(dvd8), .divisor(dvs8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(z8)
  );

  cla_seq_divider #(.WIDTH(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .start(start12), .dividend(dvd12), .divisor(dvs12),
    .busy(busy12), .done(done12), .quotient(q12), .remainder(r12), .div_by_zero(z12)
  );

  // Reference: plain integer division, divide-by-zero gives all ones / dividend
  function automatic int ref_q(input int a, input int b, input int w);
    return (b == 0) ? ((1 << w) - 1) : (a / b);
  endfunction

  function automatic int ref_r(input int a, input int b);
    return (b == 0) ? a : (a % b);
  endfunction

  // Issue one request and wait for done; returns at the negedge of the done cycle
  task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat, output int busy_n);
    int n;
    @(negedge clk);
    start8 = 1'b1; dvd8 = a; dvs8 = b;
    @(negedge clk);
    start8 = 1'b0;
    n = 1; busy_n = 0;
    while (!done8 && n < 40) begin
      if (busy8) busy_n++;
      @(negedge clk);
      n++;
    end
    lat = n;
  endtask

  task automatic run12(input logic [11:0] a, input logic [11:0] b, output int lat);
    int n;
    @(negedge clk);
    start12 = 1'b1; dvd12 = a; dvs12 = b;
    @(negedge clk);
    start12 = 1'b0;
    n = 1;
    while (!done12 && n < 40) begin
      @(negedge clk);
      n++;
    end
    lat = n;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start8 = 1'b0; dvd8 = '0; dvs8 = '0;
    start12 = 1'b0; dvd12 = '0; dvs12 = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy8, done8, q8, r8, z8} !== 19'd0) begin
      errors++;
      $display("FAIL reset8 got busy=%b done=%b q=%0d r=%0d z=%b, want all 0", busy8, done8, q8, r8, z8);
    end
    vectors++;
    if ({busy12, done12, q12, r12, z12} !== 27'd0) begin
      errors++;
      $display("FAIL reset12 got busy=%b done=%b q=%0d r=%0d z=%b, want all 0", busy12, done12, q12, r12, z12);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    int va [5] = '{100, 255, 5, 255, 200};
    int vb [5] = '{7, 1, 9, 255, 0};
    int lat, bn;
    for (int i = 0; i < 5; i++) begin
      run8(8'(va[i]), 8'(vb[i]), lat, bn);
      vectors++;
      if (lat !== ((vb[i] == 0) ? 1 : 9)) begin
        errors++;
        $display("FAIL directed_latency %0d/%0d got %0d want %0d", va[i], vb[i], lat, (vb[i] == 0) ? 1 : 9);
      end
      vectors++;
      if (bn !== ((vb[i] == 0) ? 0 : 8) || busy8 !== 1'b0) begin
        errors++;
        $display("FAIL directed_busy %0d/%0d got %0d busy cycles (busy at done=%b) want %0d",
                 va[i], vb[i], bn, busy8, (vb[i] == 0) ? 0 : 8);
      end
      vectors++;
      if (int'(q8) !== ref_q(va[i], vb[i], 8) || int'(r8) !== ref_r(va[i], vb[i]) || z8 !== (vb[i] == 0)) begin
        errors++;
        $display("FAIL directed_result %0d/%0d got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                 va[i], vb[i], q8, r8, z8, ref_q(va[i], vb[i], 8), ref_r(va[i], vb[i]), vb[i] == 0);
      end
      @(negedge clk);
      vectors++;
      if (done8 !== 1'b0) begin
        errors++;
        $display("FAIL directed_done_pulse %0d/%0d done still %b one cycle later, want 0", va[i], vb[i], done8);
      end
    end
  endtask

  task automatic test_ignored_start;
    int n;
    @(negedge clk);
    start8 = 1'b1; dvd8 = 8'd100; dvs8 = 8'd7;
    @(negedge clk);
    start8 = 1'b0;
    n = 1;
    while (!done8 && n < 40) begin
      if (n == 4) begin start8 = 1'b1; dvd8 = 8'd50; dvs8 = 8'd5; end
      else start8 = 1'b0;
      @(negedge clk);
      n++;
    end
    start8 = 1'b0;
    vectors++;
    if (n !== 9 || q8 !== 8'd14 || r8 !== 8'd2 || z8 !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start got done@%0d q=%0d r=%0d z=%b want done@9 q=14 r=2 z=0", n, q8, r8, z8);
    end
  endtask

  task automatic test_back_to_back;
    int n, first;
    @(negedge clk);
    start8 = 1'b1; dvd8 = 8'd100; dvs8 = 8'd7;
    @(negedge clk);
    n = 1; first = 0;
    while (n < 60) begin
      if (done8) begin
        if (first == 0) begin
          first = n;
          vectors++;
          if (q8 !== 8'd14 || r8 !== 8'd2) begin
            errors++;
            $display("FAIL b2b_first got q=%0d r=%0d want q=14 r=2", q8, r8);
          end
          dvd8 = 8'd99; dvs8 = 8'd10;
        end else begin
          break;
        end
      end else if (first != 0) begin
        start8 = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start8 = 1'b0;
    vectors++;
    if (first !== 9 || n !== 18) begin
      errors++;
      $display("FAIL b2b_timing got done at %0d and %0d want 9 and 18", first, n);
    end
    vectors++;
    if (q8 !== 8'd9 || r8 !== 8'd9 || z8 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second got q=%0d r=%0d z=%b want q=9 r=9 z=0", q8, r8, z8);
    end
  endtask

  task automatic test_reset_midrun;
    int seen, lat, bn;
    @(negedge clk);
    start8 = 1'b1; dvd8 = 8'd100; dvs8 = 8'd7;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy8, done8, q8, r8, z8} !== 19'd0) begin
      errors++;
      $display("FAIL midrun_reset got busy=%b done=%b q=%0d r=%0d z=%b want all 0", busy8, done8, q8, r8, z8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midrun_no_done got %0d active cycles after reset want 0", seen);
    end
    run8(8'd100, 8'd7, lat, bn);
    vectors++;
    if (lat !== 9 || q8 !== 8'd14 || r8 !== 8'd2) begin
      errors++;
      $display("FAIL midrun_recover got lat=%0d q=%0d r=%0d want lat=9 q=14 r=2", lat, q8, r8);
    end
  endtask

  task automatic test_random;
    int a, b, lat, bn;
    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, 255));
      b = (i % 16 == 0) ? 0 : ((i % 3 == 0) ? int'($urandom_range(1, 15)) : int'($urandom_range(0, 255)));
      run8(8'(a), 8'(b), lat, bn);
      vectors++;
      if (lat !== ((b == 0) ? 1 : 9) || int'(q8) !== ref_q(a, b, 8) || int'(r8) !== ref_r(a, b)
          || z8 !== (b == 0)) begin
        errors++;
        $display("FAIL rand8 %0d/%0d got lat=%0d q=%0d r=%0d z=%b want lat=%0d q=%0d r=%0d",
                 a, b, lat, q8, r8, z8, (b == 0) ? 1 : 9, ref_q(a, b, 8), ref_r(a, b));
      end
    end
    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, 4095));
      b = (i % 16 == 0) ? 0 : ((i % 3 == 0) ? int'($urandom_range(1, 31)) : int'($urandom_range(0, 4095)));
      run12(12'(a), 12'(b), lat);
      vectors++;
      if (lat !== ((b == 0) ? 1 : 13) || int'(q12) !== ref_q(a, b, 12) || int'(r12) !== ref_r(a, b)
          || z12 !== (b == 0)) begin
        errors++;
        $display("FAIL rand12 %0d/%0d got lat=%0d q=%0d r=%0d z=%b want lat=%0d q=%0d r=%0d",
                 a, b, lat, q12, r12, z12, (b == 0) ? 1 : 13, ref_q(a, b, 12), ref_r(a, b));
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_ignored_start;
    test_back_to_back;
    test_reset_midrun;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/cla_seq_divider.md
# cla_seq_divider

Multi-cycle unsigned restoring divider, the inverse-operation companion to the team's 4-bit carry-lookahead adder family. It computes quotient and remainder one bit per clock. Each trial subtraction uses a chain of 4-bit carry-lookahead subtractor slices (a − b = a + ~b + 1). It sits beside the adder blocks as the datapath divide unit and uses a start/done handshake.

## Interface
- WIDTH, 8, dividend/divisor/quotient/remainder width; must be a multiple of 4, minimum 4
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low; one clock; reset is asynchronous and active-low
- start  input  1  request; sampled only in IDLE or DONE
- dividend  input  WIDTH  numerator, captured on accepted start
- divisor  input  WIDTH  denominator, captured on accepted start
- busy  output  1  high while state is RUN
- done  output  1  one-cycle pulse, result valid
- quotient  output  WIDTH  result, held until next accepted start
- remainder  output  WIDTH  result, held until next accepted start
- div_by_zero  output  1  set with done when divisor was 0, held with results

## Operation
- States: IDLE, RUN, DONE.
- Accepted start (state IDLE or DONE, start=1) at edge k:
  - Latch the divisor into a register.
  - Load the quotient shift register with the dividend.
  - Clear the partial remainder (WIDTH+1 bits).
  - Set count = WIDTH and clear div_by_zero.
- If divisor == 0 at acceptance:
  - Skip RUN and go directly to DONE.
  - quotient = all ones, remainder = dividend, div_by_zero = 1.
- RUN step, one per cycle:
  - Shift {rem, q} left by 1.
  - Compute trial = rem_shifted − divisor. Both operands are zero-extended to WIDTH+4 bits and run through ⌈(WIDTH+1)/4⌉ chained cla_sub4 slices. The first slice has borrow-in 0, i.e. carry-in 1.
  - If there is no borrow out of the final slice: rem = trial[WIDTH:0] and q[0] = 1.
  - Otherwise rem is unchanged and q[0] = 0.
  - Decrement count.
- count reaching 0 after a step → DONE; quotient = q, remainder = rem[WIDTH-1:0].
- DONE lasts one cycle. It goes to IDLE without start, or back to RUN if start=1 is accepted.
- start while in RUN is ignored; operands and state are unaffected.
- Arithmetic is unsigned. Bit rem[WIDTH] only exists transiently before the subtract and is always 0 after each step.

## Timing
- Reset (asynchronous assertion, any state) forces:
  - state = IDLE, busy = 0, done = 0;
  - quotient = 0, remainder = 0, div_by_zero = 0;
  - internal registers cleared.
- An in-flight division is discarded. Deassertion is synchronous to clk by the system's reset synchronizer.
- Normal latency:
  - start accepted at edge k.
  - busy = 1 during cycles k+1 … k+WIDTH.
  - done = 1 during cycle k+WIDTH+1 (WIDTH+1 cycles after acceptance).
- Divide-by-zero latency: done = 1 during cycle k+1; busy is never asserted.
- Back-to-back: start held high during DONE is accepted, giving one done pulse every WIDTH+1 cycles.
- quotient, remainder and div_by_zero are registered and update in the same edge that raises done. They are stable until the edge after the next accepted start completes.
- No combinational path from any input to any output.

## Structure
- Shared package: state enum (IDLE/RUN/DONE) and a SLICE_W = 4 constant.
- Sub-module cla_sub4:
  - Ports: a[3:0], b[3:0], cin, diff[3:0], cout.
  - Generate/propagate from a and ~b.
  - Lookahead carry equations for c1..c4 identical in form to the adder's lookahead unit.
- Top instantiates (WIDTH+4)/4 slices via generate, ripple-connecting cout → cin between slices.
- Counter width: $clog2(WIDTH+1).

## Test plan
- WIDTH=8, dividend=100, divisor=7, start at cycle 0 → done only at cycle 9, quotient=14, remainder=2, div_by_zero=0, busy high cycles 1–8.
- 255 / 1 → quotient=255, remainder=0. 5 / 9 → quotient=0, remainder=5. 255 / 255 → 1, 0.
- 200 / 0 → done at cycle 1, quotient=0xFF, remainder=200, div_by_zero=1, busy never high.
- Start 100/7, then pulse start with 50/5 at cycle 4 → second request ignored; result 14/2 at cycle 9.
- Start held high continuously with 100/7, then 99/10 presented during DONE → done pulses at cycles 9 and 18; second result 9/9.
- Assert rst_n=0 mid-RUN (cycle 5) → all outputs 0 immediately, no done pulse; a fresh 100/7 after release completes normally.
- Randomized 1000 operand pairs at WIDTH=8 and WIDTH=12, checked against a / b and a % b.
